// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad front end. Drives one row per
// slot, synchronises the column lines, classifies each full frame as
// none / single / multi (ghosting), debounces presses and releases, and
// queues one code per accepted press into a small valid/ready FIFO.
module keypad_scanner #(
  parameter int  ROWS       = 4,
  parameter int  COLS       = 4,
  parameter int  SCAN_DIV   = 524288,
  parameter int  DEBOUNCE   = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int CW         = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_drive,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CW-1:0]   key_code,
  output logic            key_down,
  output logic [CW-1:0]   held_code,
  output logic            overflow
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_PRESSED} state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI}     frame_t;

  logic [COLS-1:0] r_sync1, r_sync2;
  logic [SW-1:0]   r_slot;
  logic [RW-1:0]   r_row;
  logic [1:0]      r_hits;       // hits seen so far this frame, saturates at 2
  logic [CW-1:0]   r_hit_code;   // code of the single hit seen so far
  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cand;
  logic [DW-1:0]   r_cnt;
  logic            r_key_down;
  logic [CW-1:0]   r_held;
  logic [CW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            r_full;
  logic            r_overflow;

  logic            w_slot_end, w_frame_end;
  int              w_row_bits, w_row_col, w_frame_hits;
  logic [CW-1:0]   w_row_code, w_frame_code;
  frame_t          w_frame;
  logic            w_match_cand, w_release_step, w_cnt_done;
  logic            w_push, w_release;
  logic            w_empty, w_pop, w_push_ok;
  logic [PW-1:0]   w_wr_nx;

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_slot_end  = (r_slot == SW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_row == RW'(ROWS - 1));

  // Slot counter and row index; the row advances after each slot's last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
      r_row  <= '0;
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_row  <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // One-hot row drive decoded from the row index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    row_drive        = '0;
    row_drive[r_row] = 1'b1;
  end

  // Classify the current row's sample and fold it into the frame result.
  always_comb begin
    w_row_bits = 0;
    w_row_col  = 0;
    for (int c = 0; c < COLS; c++) begin
      if (r_sync2[c]) begin
        w_row_bits = w_row_bits + 1;
        w_row_col  = c;
      end
    end
    w_row_code   = CW'(w_row_col * ROWS + int'(r_row));
    w_frame_hits = int'(r_hits) + w_row_bits;
    w_frame_code = (r_hits != 2'd0) ? r_hit_code : w_row_code;
    if (w_frame_hits == 0)      w_frame = F_NONE;
    else if (w_frame_hits == 1) w_frame = F_SINGLE;
    else                        w_frame = F_MULTI;
  end

  // Per-frame hit accumulator, cleared at each frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hits     <= '0;
      r_hit_code <= '0;
    end else if (w_frame_end) begin
      r_hits     <= '0;
    end else if (w_slot_end) begin
      r_hits <= (w_frame_hits >= 2) ? 2'd2 : 2'(w_frame_hits);
      if (w_row_bits == 1) r_hit_code <= w_row_code;
    end
  end

  assign w_match_cand   = (w_frame == F_SINGLE) && (w_frame_code == r_cand);
  assign w_release_step = (w_frame == F_NONE) ||
                          ((w_frame == F_SINGLE) && (w_frame_code != r_held));
  assign w_cnt_done     = ((int'(r_cnt) + 1) == DEBOUNCE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state, evaluated once per frame end.
  always_comb begin
    w_state_nx = r_state;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE:
          if (w_frame == F_SINGLE) w_state_nx = (DEBOUNCE == 1) ? S_PRESSED : S_PRESS_DB;
        S_PRESS_DB:
          if (w_frame != F_SINGLE)        w_state_nx = S_IDLE;
          else if (w_match_cand && w_cnt_done) w_state_nx = S_PRESSED;
        S_PRESSED:
          if (w_release_step && w_cnt_done) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM outputs: press push on entry to PRESSED, release on exit from it.
  always_comb begin
    w_push    = w_frame_end && (r_state != S_PRESSED) && (w_state_nx == S_PRESSED);
    w_release = w_frame_end && (r_state == S_PRESSED) && (w_state_nx == S_IDLE);
  end

  // Debounce candidate, match counter and held-key status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand     <= '0;
      r_cnt      <= '0;
      r_key_down <= 1'b0;
      r_held     <= '0;
    end else if (w_frame_end) begin
      case (r_state)
        S_IDLE:
          if (w_frame == F_SINGLE) begin
            r_cand <= w_frame_code;
            r_cnt  <= DW'(1);
          end
        S_PRESS_DB:
          if (w_match_cand) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_frame == F_SINGLE) begin
            r_cand <= w_frame_code;
            r_cnt  <= DW'(1);
          end
        S_PRESSED:
          r_cnt <= w_release_step ? r_cnt + 1'b1 : '0;
        default: r_cnt <= '0;
      endcase
      if (w_push) begin
        r_key_down <= 1'b1;
        r_held     <= w_frame_code;
        r_cnt      <= '0;
      end
      if (w_release) r_key_down <= 1'b0;
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr) && !r_full;
  assign w_pop     = !w_empty && key_ready;
  assign w_push_ok = w_push && (!r_full || w_pop);
  assign w_wr_nx   = r_wr_ptr + 1'b1;

  // Press-event storage; a write while full is legal when the head pops.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers and full flag
    // define which entries are live, so stale contents are never visible.
    if (!reset && w_push_ok) r_mem[r_wr_ptr] <= w_frame_code;
  end

  // FIFO pointers, full flag and dropped-press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_nx;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_full <= (w_wr_nx == r_rd_ptr);
      else if (w_pop && !w_push_ok) r_full <= 1'b0;
      r_overflow <= w_push && !w_push_ok;
    end
  end

  assign key_valid = !w_empty;
  assign key_code  = key_valid ? r_mem[r_rd_ptr] : '0;
  assign key_down  = r_key_down;
  assign held_code = r_held;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad (a 16-bit mask of held
// keys, bit index = key code) and checks the scanner cycle by cycle against
// a frame-level reference model, a directed frame table and hand sequences.
module tb_keypad_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int FRAME      = ROWS * SCAN_DIV;

  logic            clk = 1'b0;
  logic            reset;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_drive;
  logic            key_valid;
  logic            key_ready;
  logic [3:0]      key_code;
  logic            key_down;
  logic [3:0]      held_code;
  logic            overflow;

  logic [15:0]     mask;

  // Keypad: a held key at (row,col) connects the driven row to its column.
  function automatic logic [COLS-1:0] col_from(input logic [15:0] m,
                                               input logic [ROWS-1:0] rd);
    logic [COLS-1:0] c;
    c = '0;
    for (int col = 0; col < COLS; col++)
      for (int r = 0; r < ROWS; r++)
        if (rd[r] && m[col * ROWS + r]) c[col] = 1'b1;
    return c;
  endfunction

  assign col_in = col_from(mask, row_drive);

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_drive(row_drive),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_down(key_down), .held_code(held_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ovf = 0;
  int cyc   = 0;

  // Reference model state.
  logic [3:0] q[$];
  logic       m_down;
  logic [3:0] m_held;
  logic       m_ovf;
  int         run_len, run_code, rel_len;

  typedef struct {
    logic [15:0] mask;
    logic        push;
    logic [3:0]  code;
    logic        down;
    logic [3:0]  held;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_down = 1'b0; m_held = '0; m_ovf = 1'b0;
    run_len = 0; run_code = 0; rel_len = 0;
    cyc = 0;
  endtask

  // Frame-level behaviour: count held keys, then track runs of identical
  // single-key frames (press) and runs of not-the-held-key frames (release).
  task automatic model_frame(input logic [15:0] m, output logic push, output logic [3:0] code);
    int n, c;
    n = $countones(m);
    c = -1;
    push = 1'b0;
    code = '0;
    if (n == 1) for (int i = 0; i < 16; i++) if (m[i]) c = i;
    if (!m_down) begin
      if (n == 1) begin
        run_len  = (run_len > 0 && c == run_code) ? run_len + 1 : 1;
        run_code = c;
      end else begin
        run_len = 0;
      end
      if (run_len >= DEBOUNCE) begin
        push = 1'b1; code = 4'(c);
        m_down = 1'b1; m_held = 4'(c);
        run_len = 0; rel_len = 0;
      end
    end else begin
      if (n == 0 || (n == 1 && c != int'(m_held))) rel_len++;
      else rel_len = 0;
      if (rel_len >= DEBOUNCE) begin
        m_down = 1'b0; run_len = 0;
      end
    end
  endtask

  // One clock: compare at the negedge, then advance the model over the posedge.
  task automatic step();
    logic [3:0] exp_row;
    logic       do_pop, do_push, ovf_nx;
    logic [3:0] pc;
    exp_row = 4'b0001 << ((cyc / SCAN_DIV) % ROWS);
    check("row_drive", 16'(row_drive), 16'(exp_row));
    check("key_valid", 16'(key_valid), 16'(q.size() > 0));
    if (q.size() > 0) check("key_code", 16'(key_code), 16'(q[0]));
    check("key_down",  16'(key_down),  16'(m_down));
    check("held_code", 16'(held_code), 16'(m_held));
    check("overflow",  16'(overflow),  16'(m_ovf));
    if (overflow === 1'b1) n_ovf++;
    do_pop  = (q.size() > 0) && key_ready;
    do_push = 1'b0;
    pc      = '0;
    ovf_nx  = 1'b0;
    if (cyc % FRAME == FRAME - 1) model_frame(mask, do_push, pc);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < FIFO_DEPTH) q.push_back(pc);
      else ovf_nx = 1'b1;
    end
    m_ovf = ovf_nx;
    cyc++;
    @(negedge clk);
  endtask

  // One frame with a fixed key mask; mode 0/1 = fixed ready, 2 = random ready.
  task automatic run_frame(input logic [15:0] m, input int mode);
    mask = m;
    for (int i = 0; i < FRAME; i++) begin
      key_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      step();
    end
  endtask

  task automatic align_frame();
    while (cyc % FRAME != 0) step();
  endtask

  task automatic add(input logic [15:0] m, input logic p, input logic [3:0] c,
                     input logic d, input logic [3:0] h);
    vec_t v;
    v.mask = m; v.push = p; v.code = c; v.down = d; v.held = h;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rmask;
    int          ovf0;

    // Frame table: mask held for one frame, then the state right after it.
    add(16'h0000, 0, 0,  0, 0);  add(16'h0000, 0, 0,  0, 0);   // free run
    add(16'h0200, 0, 0,  0, 0);  add(16'h0200, 1, 9,  1, 9);   // (r1,c2)
    add(16'h0200, 0, 0,  1, 9);  add(16'h0000, 0, 0,  1, 9);
    add(16'h0000, 0, 0,  0, 9);  add(16'h0000, 0, 0,  0, 9);
    add(16'h0200, 0, 0,  0, 9);  add(16'h0000, 0, 0,  0, 9);   // bounce
    add(16'h0200, 0, 0,  0, 9);  add(16'h0200, 1, 9,  1, 9);
    add(16'h0000, 0, 0,  1, 9);  add(16'h0000, 0, 0,  0, 9);
    add(16'h0041, 0, 0,  0, 9);  add(16'h0041, 0, 0,  0, 9);   // ghost rows
    add(16'h0001, 0, 0,  0, 9);  add(16'h0001, 1, 0,  1, 0);
    add(16'h0000, 0, 0,  1, 0);  add(16'h0000, 0, 0,  0, 0);
    add(16'h2002, 0, 0,  0, 0);  add(16'h0000, 0, 0,  0, 0);   // ghost in a row
    add(16'h0020, 0, 0,  0, 0);  add(16'h0020, 1, 5,  1, 5);
    add(16'h0080, 0, 0,  1, 5);  add(16'h0080, 0, 0,  0, 5);   // other key releases
    add(16'h0080, 0, 0,  0, 5);  add(16'h0080, 1, 7,  1, 7);
    add(16'h0000, 0, 0,  1, 7);  add(16'h0000, 0, 0,  0, 7);
    add(16'h0008, 0, 0,  0, 7);  add(16'h1000, 0, 0,  0, 7);   // candidate change
    add(16'h1000, 1, 12, 1, 12); add(16'h0000, 0, 0,  1, 12);
    add(16'h0000, 0, 0,  0, 12); add(16'h0004, 0, 0,  0, 12);
    add(16'h0004, 1, 2,  1, 2);  add(16'h0000, 0, 0,  1, 2);
    add(16'h0104, 0, 0,  1, 2);  add(16'h0000, 0, 0,  1, 2);   // multi keeps held
    add(16'h0000, 0, 0,  0, 2);

    reset = 1'b1; mask = '0; key_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_row_drive", 16'(row_drive), 16'h0001);
    check("rst_key_valid", 16'(key_valid), 16'h0000);
    check("rst_key_code",  16'(key_code),  16'h0000);
    check("rst_key_down",  16'(key_down),  16'h0000);
    check("rst_held_code", 16'(held_code), 16'h0000);
    check("rst_overflow",  16'(overflow),  16'h0000);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      run_frame(tbl[i].mask, 1);
      check("tbl_valid", 16'(key_valid), 16'(tbl[i].push));
      if (tbl[i].push) check("tbl_code", 16'(key_code), 16'(tbl[i].code));
      check("tbl_down", 16'(key_down),  16'(tbl[i].down));
      check("tbl_held", 16'(held_code), 16'(tbl[i].held));
    end

    // Overflow: three presses with nobody draining the FIFO.
    ovf0 = n_ovf;
    run_frame(16'h0002, 0); run_frame(16'h0002, 0); run_frame(16'h0000, 0); run_frame(16'h0000, 0);
    run_frame(16'h0010, 0); run_frame(16'h0010, 0); run_frame(16'h0000, 0); run_frame(16'h0000, 0);
    run_frame(16'h8000, 0); run_frame(16'h8000, 0); run_frame(16'h0000, 0); run_frame(16'h0000, 0);
    check("ovf_pulses", 16'(n_ovf - ovf0), 16'd1);
    check("ovf_head_valid", 16'(key_valid), 16'h0001);
    check("ovf_head_code",  16'(key_code),  16'd1);
    key_ready = 1'b1;
    step();
    check("pop1_valid", 16'(key_valid), 16'h0001);
    check("pop1_code",  16'(key_code),  16'd4);
    step();
    check("pop2_valid", 16'(key_valid), 16'h0000);
    key_ready = 1'b0;
    align_frame();

    // Reset mid-debounce with one entry queued.
    run_frame(16'h0008, 0); run_frame(16'h0008, 0);
    run_frame(16'h0000, 0); run_frame(16'h0000, 0);
    run_frame(16'h0040, 0);
    check("pre_rst_valid", 16'(key_valid), 16'h0001);
    repeat (5) step();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_row_drive", 16'(row_drive), 16'h0001);
    check("mid_rst_key_valid", 16'(key_valid), 16'h0000);
    check("mid_rst_key_code",  16'(key_code),  16'h0000);
    check("mid_rst_key_down",  16'(key_down),  16'h0000);
    check("mid_rst_held_code", 16'(held_code), 16'h0000);
    check("mid_rst_overflow",  16'(overflow),  16'h0000);
    reset = 1'b0;
    model_reset();
    run_frame(16'h0040, 1);
    check("post_rst_no_push", 16'(key_valid), 16'h0000);
    run_frame(16'h0040, 1);
    check("post_rst_push",    16'(key_valid), 16'h0001);
    check("post_rst_code",    16'(key_code),  16'd6);

    // Random frames with random back-pressure, checked by the model.
    rmask = '0;
    for (int f = 0; f < 200; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ;
        4, 5:       rmask = '0;
        6, 7, 8:    rmask = 16'h0001 << $urandom_range(0, 15);
        default:    rmask = (16'h0001 << $urandom_range(0, 15)) |
                            (16'h0001 << $urandom_range(0, 15));
      endcase
      run_frame(rmask, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
